// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline controls in, instruction-memory port, F/D register payload out.
interface fetch_unit_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned EXC_W  = 5;

  logic             halt;
  logic             req;
  logic             eret_req;
  logic [XLEN-1:0]  epc;
  logic             d_redirect;
  logic [XLEN-1:0]  d_target;
  logic             d_is_bj;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic [XLEN-1:0]  f_pc;
  logic [XLEN-1:0]  f_instr;
  logic             f_new_instr;
  logic [EXC_W-1:0] f_excCode;
  logic             f_delaySlot;

  // Fetch unit side
  modport master (
    input  halt, req, eret_req, epc, d_redirect, d_target, d_is_bj, imem_rdata,
    output imem_addr, f_pc, f_instr, f_new_instr, f_excCode, f_delaySlot
  );

  // Pipeline / memory environment side
  modport slave (
    output halt, req, eret_req, epc, d_redirect, d_target, d_is_bj, imem_rdata,
    input  imem_addr, f_pc, f_instr, f_new_instr, f_excCode, f_delaySlot
  );
endinterface

// File: rtl/fetch_unit.sv
// F stage of the 5-stage MIPS pipeline: PC register, next-PC selection and
// fetch-address (AdEL) checking.
// Optional feature macro: FETCH_ADDR_CHECK_EN enables AdEL detection for
// misaligned fetches and fetches outside [IM_BASE, IM_BASE + 4*IM_WORDS).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`ifdef FETCH_ADDR_CHECK_EN
  ,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int unsigned IM_WORDS   = 4096
`endif
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned EXC_W    = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = EXC_W'(0);
  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            adel;

  // Next-PC priority: reset > req > eret > halt > redirect > sequential.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (reset) begin
      pc_d = RESET_PC;
    end else if (bus.req) begin
      pc_d = EXC_VECTOR;
    end else if (bus.eret_req) begin
      pc_d = bus.epc;
    end else if (bus.halt) begin
      pc_d = pc_q;
    end else if (bus.d_redirect) begin
      pc_d = bus.d_target;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

`ifdef FETCH_ADDR_CHECK_EN
  // Window bounds in 33 bits so the exclusive end never wraps to zero.
  localparam logic [XLEN:0] WIN_LO = {1'b0, IM_BASE};
  localparam logic [XLEN:0] WIN_HI = WIN_LO + ((XLEN+1)'(IM_WORDS) << 2);

  // Misaligned or out-of-window fetch raises AdEL.
  always_comb begin
    adel = (pc_q[1:0] != 2'b00)
        || ({1'b0, pc_q} <  WIN_LO)
        || ({1'b0, pc_q} >= WIN_HI);
  end
`else
  // Address checking compiled out.
  always_comb begin
    adel = 1'b0;
  end
`endif

  // F outputs follow the PC; eret squash overrides AdEL.
  always_comb begin
    bus.imem_addr   = pc_q;
    bus.f_pc        = pc_q;
    bus.f_instr     = bus.imem_rdata;
    bus.f_new_instr = 1'b1;
    bus.f_excCode   = EXC_NONE;
    bus.f_delaySlot = bus.d_is_bj;
    if (bus.eret_req) begin
      bus.f_instr     = '0;
      bus.f_new_instr = 1'b0;
      bus.f_delaySlot = 1'b0;
    end else if (adel) begin
      bus.f_instr     = '0;
      bus.f_excCode   = EXC_ADEL;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random + directed control sequences,
// expected F outputs from a reference model, checked by a separate monitor.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam longint      WIN_LO     = 64'h3000;
  localparam longint      WIN_HI     = 64'h3000 + 4 * 4096;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        new_i;
    logic [4:0]  exc;
    logic        ds;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: an arbitrary address-dependent pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [31:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: fetch fault if misaligned or outside the legal byte window.
  function automatic bit fault(input logic [31:0] pc);
`ifdef FETCH_ADDR_CHECK_EN
    longint p;
    p = longint'(pc);
    return (pc % 4 != 0) || (p < WIN_LO) || (p >= WIN_HI);
`else
    return (pc == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Drive one cycle of controls, predict outputs and the next PC.
  task automatic cycle(input bit rst, input bit hlt, input bit rq, input bit er,
                       input logic [31:0] ep, input bit rd, input logic [31:0] tgt,
                       input bit bj);
    exp_t e;
    reset          = rst;
    bus.halt       = hlt;
    bus.req        = rq;
    bus.eret_req   = er;
    bus.epc        = ep;
    bus.d_redirect = rd;
    bus.d_target   = tgt;
    bus.d_is_bj    = bj;
    e.pc = model_pc;
    if (er) begin
      e.instr = 32'h0; e.new_i = 1'b0; e.exc = 5'd0; e.ds = 1'b0;
    end else if (fault(model_pc)) begin
      e.instr = 32'h0; e.new_i = 1'b1; e.exc = 5'd4; e.ds = bj;
    end else begin
      e.instr = mem_word(model_pc); e.new_i = 1'b1; e.exc = 5'd0; e.ds = bj;
    end
    exp_q.push_back(e);
    pushed++;
    if (rst)       model_pc = RESET_PC;
    else if (rq)   model_pc = EXC_VECTOR;
    else if (er)   model_pc = ep;
    else if (hlt)  model_pc = model_pc;
    else if (rd)   model_pc = tgt;
    else           model_pc = model_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic free_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      popped++;
      chk("f_pc",        bus.f_pc,               e.pc);
      chk("imem_addr",   bus.imem_addr,          e.pc);
      chk("f_instr",     bus.f_instr,            e.instr);
      chk("f_new_instr", 32'(bus.f_new_instr),   32'(e.new_i));
      chk("f_excCode",   32'(bus.f_excCode),     32'(e.exc));
      chk("f_delaySlot", 32'(bus.f_delaySlot),   32'(e.ds));
    end
  end

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
      1: a = 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4) + 32'($urandom_range(1, 3));
      2: a = 32'h0000_2FFC;
      3: a = 32'h0000_6FFC;
      4: a = 32'h0000_7000;
      5: a = 32'hFFFF_FFFC;
      6: a = $urandom();
      default: a = 32'h0000_3000 + 32'($urandom_range(0, 63) * 4);
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b1;
    bus.halt = 1'b0; bus.req = 1'b0; bus.eret_req = 1'b0; bus.epc = '0;
    bus.d_redirect = 1'b0; bus.d_target = '0; bus.d_is_bj = 1'b0;
    @(posedge clk);
    #1;
    model_pc = RESET_PC;

    // Reset state, then sequential fetch 3000..300C.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    free_cycle(); free_cycle(); free_cycle(); free_cycle();
    // Branch in D at PC 3010: delay slot flagged, next PC 3100.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1);
    free_cycle();
    // Halt with a pending redirect: PC held, redirect consumed on release.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3200, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3200, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3200, 1'b1);
    free_cycle();
    // req beats halt and redirect.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_3300, 1'b0);
    free_cycle();
    // eret squashes F and returns to epc.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3044, 1'b0, 32'h0, 1'b1);
    free_cycle();
    // Fetch-address boundary cases.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3002, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_7000, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_6FFC, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2FFC, 1'b0);
    // Sequential wrap past 0xFFFFFFFC.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    free_cycle(); free_cycle();
    // Reset while halted with a redirect pending.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3400, 1'b1);
    free_cycle();

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0),
            pick_addr(),
            ($urandom_range(0, 3) == 0),
            pick_addr(),
            ($urandom_range(0, 2) == 0));
    end

    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (popped != pushed || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: checked %0d want %0d", popped, pushed);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
